lcd_reader: RTL and testbench

- Read-side counterpart to the LCD nibble writer on the Spartan-3E HD44780 character LCD, which uses a 4-bit bus with RS, RW and E.
- Runs one 8-bit read transaction as two nibble strobes, upper nibble first. With RS=0 it reads the busy flag and address counter; with RS=1 it reads DDRAM/CGRAM data.
- Optional busy-poll mode repeats status reads until BF=0, so the sequencer can replace fixed 40 us waits.
- Sits beside the writer; the top-level bus mux grants the LCD pins to this block while oBusy=1.

---
 rtl/lcd_pkg.sv | 34 +++
 rtl/lcd_delay_counter.sv | 30 +++
 rtl/lcd_reader.sv | 147 ++++++++++++++
 tb/tb_lcd_reader.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 4-bit LCD writer and reader.
// Timing constants assume a 50 MHz system clock.
package lcd_pkg;

  localparam int CNT_W    = 16;
  localparam int T_SETUP  = 2;
  localparam int T_E_HIGH = 12;
  localparam int T_E_LOW  = 38;
  localparam int T_HOLD   = 2;
  localparam int T_40US   = 2000;
  localparam int BF_BIT   = 7;

  typedef enum logic [2:0] {
    WR_IDLE,
    WR_SETUP,
    WR_E_HI,
    WR_E_LO,
    WR_WAIT
  } wr_state_t;

  typedef enum logic [3:0] {
    RD_IDLE,
    RD_RELEASE,
    RD_SETUP,
    RD_E_HI_1,
    RD_E_LO_1,
    RD_E_HI_2,
    RD_E_LO_2,
    RD_EVAL,
    RD_HOLD,
    RD_DONE
  } rd_state_t;

endpackage

// File: rtl/lcd_delay_counter.sv
// Loadable down-counter timing LCD state durations.
// A load of N makes expired rise on the N-th cycle of the new state.
module lcd_delay_counter
  import lcd_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         expired
);

  logic [W-1:0] count;

  // reload on state entry, otherwise count down to zero and stay
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value - W'(1);
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/lcd_reader.sv
// HD44780 4-bit read sequencer: one byte as two nibble strobes,
// with optional busy-flag polling until BF=0 or POLL_MAX reads.
module lcd_reader
  import lcd_pkg::*;
#(
  parameter int T_SETUP  = lcd_pkg::T_SETUP,
  parameter int T_E_HIGH = lcd_pkg::T_E_HIGH,
  parameter int T_E_LOW  = lcd_pkg::T_E_LOW,
  parameter int T_HOLD   = lcd_pkg::T_HOLD,
  parameter int POLL_MAX = 1024
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iStart,
  input  logic       iRS,
  input  logic       iPollBusy,
  input  logic [3:0] iLCD_Data,
  output logic       oLCD_RS,
  output logic       oLCD_RW,
  output logic       oLCD_E,
  output logic       oBusRelease,
  output logic [7:0] oData,
  output logic       oDataValid,
  output logic       oTimeout,
  output logic       oBusy
);

  localparam int PW = (POLL_MAX > 1) ? $clog2(POLL_MAX) : 1;
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX - 1);

  rd_state_t        state;
  rd_state_t        state_next;
  logic             poll;
  logic [PW-1:0]    poll_cnt;
  logic             load;
  logic [CNT_W-1:0] load_value;
  logic             expired;
  logic             accept;
  logic             bf;
  logic             e_n;
  logic             rw_n;
  logic             rel_n;

  assign accept = (state == RD_IDLE) && iStart;
  assign bf     = oData[BF_BIT];
  assign oBusy  = oBusRelease;

  lcd_delay_counter #(
    .W(CNT_W)
  ) u_delay (
    .clk       (Clock),
    .rst       (Reset),
    .load      (load),
    .load_value(load_value),
    .expired   (expired)
  );

  // state register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= RD_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // next state, counter reload and next-cycle pin levels
  always_comb begin
    state_next = state;
    unique case (state)
      RD_IDLE:    if (iStart)  state_next = RD_RELEASE;
      RD_RELEASE: if (expired) state_next = RD_SETUP;
      RD_SETUP:   if (expired) state_next = RD_E_HI_1;
      RD_E_HI_1:  if (expired) state_next = RD_E_LO_1;
      RD_E_LO_1:  if (expired) state_next = RD_E_HI_2;
      RD_E_HI_2:  if (expired) state_next = RD_E_LO_2;
      RD_E_LO_2:  if (expired) state_next = RD_EVAL;
      RD_EVAL: begin
        if (expired) begin
          if (poll && bf && (poll_cnt != POLL_LAST)) begin
            state_next = RD_SETUP;
          end else begin
            state_next = RD_HOLD;
          end
        end
      end
      RD_HOLD:    if (expired) state_next = RD_DONE;
      RD_DONE:    if (expired) state_next = RD_IDLE;
      default:    state_next = RD_IDLE;
    endcase

    load = (state_next != state);
    unique case (state_next)
      RD_SETUP:  load_value = CNT_W'(T_SETUP);
      RD_E_HI_1: load_value = CNT_W'(T_E_HIGH);
      RD_E_HI_2: load_value = CNT_W'(T_E_HIGH);
      RD_E_LO_1: load_value = CNT_W'(T_E_LOW);
      RD_E_LO_2: load_value = CNT_W'(T_E_LOW);
      RD_HOLD:   load_value = CNT_W'(T_HOLD);
      default:   load_value = CNT_W'(1);
    endcase

    e_n   = (state_next == RD_E_HI_1) || (state_next == RD_E_HI_2);
    rw_n  = !(state_next inside {RD_IDLE, RD_RELEASE, RD_DONE});
    rel_n = (state_next != RD_IDLE);
  end

  // registered pins, nibble capture and result pulses
  always_ff @(posedge Clock) begin
    if (Reset) begin
      oLCD_RS     <= 1'b0;
      oLCD_RW     <= 1'b0;
      oLCD_E      <= 1'b0;
      oBusRelease <= 1'b0;
      oData       <= 8'h00;
      oDataValid  <= 1'b0;
      oTimeout    <= 1'b0;
      poll        <= 1'b0;
      poll_cnt    <= '0;
    end else begin
      oLCD_RW     <= rw_n;
      oLCD_E      <= e_n;
      oBusRelease <= rel_n;
      oDataValid  <= 1'b0;
      oTimeout    <= 1'b0;
      if (accept) begin
        oLCD_RS  <= iRS && !iPollBusy;
        poll     <= iPollBusy;
        poll_cnt <= '0;
      end else if (state_next == RD_IDLE) begin
        oLCD_RS <= 1'b0;
      end
      if ((state == RD_E_HI_1) && expired) oData[7:4] <= iLCD_Data;
      if ((state == RD_E_HI_2) && expired) oData[3:0] <= iLCD_Data;
      if ((state == RD_EVAL) && expired) begin
        if (!poll || !bf) begin
          oDataValid <= 1'b1;
        end else if (poll_cnt == POLL_LAST) begin
          oTimeout <= 1'b1;
        end else begin
          poll_cnt <= poll_cnt + PW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_reader.sv
// Self-checking bench for lcd_reader with an LCD response model
// and a transaction-level reference for reads, latency and results.
module tb_lcd_reader;

  localparam int TS   = 2;
  localparam int TH   = 12;
  localparam int TL   = 38;
  localparam int THD  = 2;
  localparam int PMAX = 4;
  localparam int RD   = TS + 2 * (TH + TL) + 1;

  logic       clk = 1'b0;
  logic       Reset;
  logic       iStart;
  logic       iRS;
  logic       iPollBusy;
  logic [3:0] iLCD_Data;
  logic       oLCD_RS;
  logic       oLCD_RW;
  logic       oLCD_E;
  logic       oBusRelease;
  logic [7:0] oData;
  logic       oDataValid;
  logic       oTimeout;
  logic       oBusy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lcd_reader #(
    .T_SETUP (TS),
    .T_E_HIGH(TH),
    .T_E_LOW (TL),
    .T_HOLD  (THD),
    .POLL_MAX(PMAX)
  ) dut (
    .Clock      (clk),
    .Reset      (Reset),
    .iStart     (iStart),
    .iRS        (iRS),
    .iPollBusy  (iPollBusy),
    .iLCD_Data  (iLCD_Data),
    .oLCD_RS    (oLCD_RS),
    .oLCD_RW    (oLCD_RW),
    .oLCD_E     (oLCD_E),
    .oBusRelease(oBusRelease),
    .oData      (oData),
    .oDataValid (oDataValid),
    .oTimeout   (oTimeout),
    .oBusy      (oBusy)
  );

  typedef struct {
    bit         rs;
    bit         poll;
    int         nbusy;
    logic [7:0] fin;
    logic [7:0] resp [8];
    int         reads;
    bit         valid;
    bit         tmo;
    logic [7:0] data;
    bit         exp_rs;
    int         lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  // transaction-level reference: bytes the LCD returns and the outcome
  function automatic vec_t model(input bit rs, input bit poll,
                                 input int nbusy, input logic [7:0] fin);
    vec_t v;
    v.rs    = rs;
    v.poll  = poll;
    v.nbusy = nbusy;
    v.fin   = fin;
    for (int i = 0; i < 8; i++) v.resp[i] = 8'h00;
    if (poll) begin
      for (int i = 0; i < nbusy && i < 8; i++)
        v.resp[i] = 8'h80 | 8'(i * 5 + 3);
      if (nbusy < 8) v.resp[nbusy] = fin & 8'h7f;
      v.reads = (nbusy + 1 < PMAX) ? nbusy + 1 : PMAX;
      v.tmo   = (nbusy >= PMAX);
    end else begin
      v.resp[0] = fin;
      v.reads   = 1;
      v.tmo     = 1'b0;
    end
    v.valid  = !v.tmo;
    v.data   = v.resp[v.reads - 1];
    v.exp_rs = rs && !poll;
    v.lat    = 1 + RD * v.reads;
    return v;
  endfunction

  task automatic run(input vec_t v, input string tag);
    int n = 0;
    int nib = 0;
    int erun = 0;
    int ewbad = 0;
    int epulses = 0;
    int nvalid = 0;
    int ntmo = 0;
    int evlat = -1;
    int busy_last = -1;
    int rwviol = 0;
    int rsbad = 0;
    bit rel_first = 1'b0;
    bit expired_wait = 1'b0;
    logic e_prev = 1'b0;
    logic [7:0] b;
    logic [7:0] held;
    @(negedge clk);
    chk({tag, "_idle_before"}, oBusy, 1'b0);
    iStart = 1'b1;
    iRS = v.rs;
    iPollBusy = v.poll;
    @(negedge clk);
    iStart = 1'b0;
    iRS = 1'($urandom);
    iPollBusy = 1'($urandom);
    forever begin
      if (n == 0) rel_first = oBusRelease && !oLCD_RW && !oLCD_E;
      if (oLCD_RW && !oBusRelease) rwviol++;
      if (oLCD_RW && (oLCD_RS !== v.exp_rs)) rsbad++;
      if (oLCD_E && !e_prev) begin
        epulses++;
        b = ((nib >> 1) < 8) ? v.resp[nib >> 1] : 8'h00;
        iLCD_Data = nib[0] ? b[3:0] : b[7:4];
        nib++;
        erun = 0;
      end
      if (oLCD_E) erun++;
      if (!oLCD_E && e_prev && erun != TH) ewbad++;
      e_prev = oLCD_E;
      if (oDataValid) begin
        nvalid++;
        evlat = n;
      end
      if (oTimeout) begin
        ntmo++;
        evlat = n;
      end
      if (oBusy) busy_last = n;
      if (!oBusy && n > 0) break;
      if (n > RD * PMAX + 40) begin
        expired_wait = 1'b1;
        break;
      end
      @(negedge clk);
      n++;
    end
    chk({tag, "_no_hang"}, expired_wait, 1'b0);
    chk({tag, "_release_first"}, rel_first, 1'b1);
    chk({tag, "_e_pulses"}, epulses, 2 * v.reads);
    chk({tag, "_e_width"}, ewbad, 0);
    chk({tag, "_rw_bus"}, rwviol, 0);
    chk({tag, "_rs"}, rsbad, 0);
    chk({tag, "_valid_cnt"}, nvalid, v.valid);
    chk({tag, "_timeout_cnt"}, ntmo, v.tmo);
    chk({tag, "_latency"}, evlat, v.lat);
    chk({tag, "_busy_len"}, busy_last, RD * v.reads + THD + 1);
    chk({tag, "_data"}, oData, v.data);
    held = oData;
    iLCD_Data = 4'($urandom);
    repeat (3) @(negedge clk);
    chk({tag, "_data_hold"}, oData, v.data);
    chk({tag, "_idle_pins"}, {oLCD_E, oLCD_RW, oBusRelease, oLCD_RS},
        4'b0000);
    if (held !== v.data) $display("note: %s held %0h", tag, held);
  endtask

  task automatic restart_and_reset();
    iStart = 1'b1;
    iRS = 1'b1;
    iPollBusy = 1'b0;
    @(negedge clk);
    iStart = 1'b0;
    for (int n = 1; n <= 22; n++) begin
      @(negedge clk);
      if (n == 3) iLCD_Data = 4'hA;
      if (n == 6) begin
        iStart = 1'b1;
        iRS = 1'b0;
      end
      if (n == 7) iStart = 1'b0;
      if (n == 14) chk("restart_e_high", {oLCD_E, oLCD_RW, oLCD_RS}, 3'b111);
      if (n == 15) chk("restart_e_fall", {oLCD_E, oLCD_RW}, 2'b01);
      if (n == 16) chk("restart_upper", oData[7:4], 4'hA);
      if (n == 20) Reset = 1'b1;
      if (n == 21) begin
        chk("rst_mid_pins",
            {oLCD_E, oLCD_RW, oBusRelease, oBusy, oLCD_RS}, 5'b00000);
        chk("rst_mid_data", oData, 8'h00);
        chk("rst_mid_pulses", {oDataValid, oTimeout}, 2'b00);
        Reset = 1'b0;
      end
      if (n == 22) chk("rst_mid_stay_idle", {oBusy, oLCD_E}, 2'b00);
    end
  endtask

  initial begin
    Reset = 1'b1;
    iStart = 1'b0;
    iRS = 1'b0;
    iPollBusy = 1'b0;
    iLCD_Data = 4'h0;
    repeat (3) @(negedge clk);
    chk("reset_pins", {oLCD_RS, oLCD_RW, oLCD_E, oBusRelease}, 4'b0000);
    chk("reset_data", oData, 8'h00);
    chk("reset_flags", {oDataValid, oTimeout, oBusy}, 3'b000);
    Reset = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", {oBusy, oLCD_E, oLCD_RW}, 3'b000);

    vecs.push_back(model(1'b1, 1'b0, 0, 8'hA5));
    vecs.push_back(model(1'b0, 1'b0, 0, 8'h0C));
    vecs.push_back(model(1'b0, 1'b1, 3, 8'h07));
    vecs.push_back(model(1'b0, 1'b1, 6, 8'h11));
    vecs.push_back(model(1'b1, 1'b1, 0, 8'h3C));
    vecs.push_back(model(1'b0, 1'b0, 0, 8'h8F));
    vecs.push_back(model(1'b1, 1'b1, 4, 8'h22));
    for (int i = 0; i < 10; i++)
      vecs.push_back(model(1'($urandom), 1'($urandom),
                           int'($urandom_range(0, 5)), 8'($urandom)));

    foreach (vecs[i]) run(vecs[i], $sformatf("v%0d", i));

    restart_and_reset();
    run(model(1'b1, 1'b0, 0, 8'h5A), "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
